gray_position_tracker: RTL and testbench



---
 rtl/gray_pkg.sv | 32 +++
 rtl/gray_glitch_filter.sv | 60 ++++++
 rtl/gray_position_tracker.sv | 117 +++++++++++
 tb/tb_gray_position_tracker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared helpers for the Gray position tracker: Gray-to-binary conversion,
// step classification codes and signed turns-counter limits.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN,
        STEP_JUMP
    } step_e;

    // Callers zero-extend narrower words; leading zeros leave the prefix XOR unchanged.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int turns_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int turns_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/gray_glitch_filter.sv
// Input glitch filter: forwards a Gray word once it has been seen on
// FILTER_LEN consecutive valid samples; one registered cycle of latency.
module gray_glitch_filter
    import gray_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] gray_out
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] gray_q;
    logic             valid_q;
    logic             fire;

    // The counter parks at FILTER_LEN so a stable run fires exactly once.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        fire   = 1'b0;
        if (in_valid) begin
            if (cnt_q != '0 && gray_in == last_q) begin
                if (cnt_q != CNT_W'(FILTER_LEN)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    fire  = (cnt_q == CNT_W'(FILTER_LEN - 1));
                end
            end else begin
                cnt_d  = CNT_W'(1);
                last_d = gray_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            last_q  <= '0;
            gray_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            valid_q <= fire;
            if (fire) gray_q <= gray_in;
        end
    end

    assign out_valid = valid_q;
    assign gray_out  = gray_q;

endmodule

// File: rtl/gray_position_tracker.sv
// Gray encoder position tracker: 2-stage Gray-to-binary pipeline with step
// classification and a saturating signed turns counter. Optional GRAY_FILTER_EN.
module gray_position_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int TURN_W     = 8,
    parameter int FILTER_LEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  gray_in,
    input  logic              err_clr,
    output logic              out_valid,
    output logic [WIDTH-1:0]  bin_out,
    output logic              step_up,
    output logic              step_down,
    output logic              jump_err,
    output logic              err_sticky,
    output logic [TURN_W-1:0] turns
);

    localparam logic signed [TURN_W-1:0] TURNS_MAX = TURN_W'(turns_max(TURN_W));
    localparam logic signed [TURN_W-1:0] TURNS_MIN = TURN_W'(turns_min(TURN_W));

    logic             s0_valid;
    logic [WIDTH-1:0] s0_gray;

`ifdef GRAY_FILTER_EN
    gray_glitch_filter #(
        .WIDTH     (WIDTH),
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .gray_in  (gray_in),
        .out_valid(s0_valid),
        .gray_out (s0_gray)
    );
`else
    logic unused_filter_len;
    assign unused_filter_len = FILTER_LEN[0];
    assign s0_valid = in_valid;
    assign s0_gray  = gray_in;
`endif

    logic [1:0]              vld_pipe_q;
    logic [WIDTH-1:0]        g1_q;
    logic [WIDTH-1:0]        bin_q, prev_q;
    logic                    primed_q;
    logic                    up_q, down_q, jump_q, sticky_q;
    logic signed [TURN_W-1:0] turns_q, turns_d;
    logic [WIDTH-1:0]        bin_d, delta;
    step_e                   step_d;

    assign bin_d = WIDTH'(gray2bin(GRAY_MAX_W'(g1_q)));
    assign delta = bin_d - prev_q;

    always_comb begin
        step_d  = STEP_NONE;
        turns_d = turns_q;
        if (primed_q) begin
            if (delta == WIDTH'(1))           step_d = STEP_UP;
            else if (delta == '1)             step_d = STEP_DOWN;
            else if (delta != '0)             step_d = STEP_JUMP;
        end
        // A revolution boundary is crossed only on a single step across the 0 / all-ones seam.
        if (step_d == STEP_UP && prev_q == '1 && turns_q != TURNS_MAX)
            turns_d = turns_q + TURN_W'(1);
        else if (step_d == STEP_DOWN && prev_q == '0 && turns_q != TURNS_MIN)
            turns_d = turns_q - TURN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            g1_q       <= '0;
            bin_q      <= '0;
            prev_q     <= '0;
            primed_q   <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            jump_q     <= 1'b0;
            sticky_q   <= 1'b0;
            turns_q    <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], s0_valid};
            if (s0_valid) g1_q <= s0_gray;
            up_q   <= 1'b0;
            down_q <= 1'b0;
            jump_q <= 1'b0;
            if (vld_pipe_q[0]) begin
                bin_q    <= bin_d;
                prev_q   <= bin_d;
                primed_q <= 1'b1;
                up_q     <= (step_d == STEP_UP);
                down_q   <= (step_d == STEP_DOWN);
                jump_q   <= (step_d == STEP_JUMP);
                turns_q  <= turns_d;
            end
            // A new jump outranks a coincident clear.
            if (vld_pipe_q[0] && step_d == STEP_JUMP) sticky_q <= 1'b1;
            else if (err_clr)                        sticky_q <= 1'b0;
        end
    end

    assign out_valid  = vld_pipe_q[1];
    assign bin_out    = bin_q;
    assign step_up    = up_q;
    assign step_down  = down_q;
    assign jump_err   = jump_q;
    assign err_sticky = sticky_q;
    assign turns      = turns_q;

endmodule

// File: tb/tb_gray_position_tracker.sv
// Scoreboard bench for gray_position_tracker: a cycle-level reference model
// pushes expected outputs, a monitor pops and compares on each out_valid.
module tb_gray_position_tracker;

    localparam int W      = 4;
    localparam int TW     = 2;
    localparam int FL     = 3;
    localparam int N      = 1 << W;
    localparam int TMAX   = (1 << (TW - 1)) - 1;
    localparam int TMIN   = -(1 << (TW - 1));
`ifdef GRAY_FILTER_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  gray_in = '0;
    logic          err_clr = 1'b0;
    logic          out_valid, step_up, step_down, jump_err, err_sticky;
    logic [W-1:0]  bin_out;
    logic [TW-1:0] turns;

    gray_position_tracker #(.WIDTH(W), .TURN_W(TW), .FILTER_LEN(FL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in), .err_clr(err_clr),
        .out_valid(out_valid), .bin_out(bin_out), .step_up(step_up), .step_down(step_down),
        .jump_err(jump_err), .err_sticky(err_sticky), .turns(turns)
    );

    always #5 clk = ~clk;

    typedef struct { int bin; bit up; bit dn; bit jmp; bit sticky; int turns; } exp_t;
    typedef struct { int t; int g; } smp_t;

    exp_t exp_q[$];
    smp_t inflight[$];

    int n_total = 0;
    int n_pass  = 0;
    int t_now   = 0;

    // reference model state
    bit m_primed = 0;
    int m_prev   = 0;
    int m_turns  = 0;
    bit m_sticky = 0;
    int f_last   = 0;
    int f_run    = 0;
    int last_bin = 0;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic int g2b(input int g);
        int b = 0;
        for (int k = 0; k < W; k++) b ^= (g >> k);
        return b & (N - 1);
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & (N - 1);
    endfunction

    task automatic model_step(input bit v, input int g, input bit clr, input bit r);
        exp_t e;
        smp_t s;
        int   d;
        bit   ret;
        if (r) begin
            inflight.delete();
            m_primed = 0; m_prev = 0; m_turns = 0; m_sticky = 0; f_run = 0; f_last = 0;
            return;
        end
        if (v) begin
`ifdef GRAY_FILTER_EN
            if (f_run > 0 && g == f_last) begin
                if (f_run < FL) begin
                    f_run++;
                    if (f_run == FL) inflight.push_back('{t_now, g});
                end
            end else begin
                f_last = g;
                f_run  = 1;
            end
`else
            inflight.push_back('{t_now, g});
`endif
        end
        ret = 0;
        e = '{0, 0, 0, 0, 0, 0};
        if (inflight.size() > 0 && inflight[0].t == t_now - (LAT - 1)) begin
            s = inflight.pop_front();
            ret = 1;
            e.bin = g2b(s.g);
            if (m_primed) begin
                d = (e.bin - m_prev + N) % N;
                e.up  = (d == 1);
                e.dn  = (d == N - 1);
                e.jmp = (d != 0) && !e.up && !e.dn;
                if (e.up && m_prev == N - 1 && m_turns < TMAX) m_turns++;
                if (e.dn && m_prev == 0 && m_turns > TMIN) m_turns--;
            end
            m_primed = 1;
            m_prev   = e.bin;
        end
        if (ret && e.jmp) m_sticky = 1;
        else if (clr)     m_sticky = 0;
        if (ret) begin
            e.sticky = m_sticky;
            e.turns  = m_turns;
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc(input bit v, input int g, input bit clr, input bit r);
        @(negedge clk);
        in_valid = v; gray_in = W'(g); err_clr = clr; rst = r;
        model_step(v, g, clr, r);
        if (v) last_bin = g2b(g);
        t_now++;
    endtask

    task automatic put_bin(input int b);
        cyc(1, b2g(b), 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    // monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                n_total++;
                if (int'(bin_out) == e.bin && step_up == e.up && step_down == e.dn &&
                    jump_err == e.jmp && err_sticky == e.sticky && int'($signed(turns)) == e.turns)
                    n_pass++;
                else
                    $display("FAIL output: got bin=%0d up=%0b dn=%0b jmp=%0b sticky=%0b turns=%0d, expected bin=%0d up=%0b dn=%0b jmp=%0b sticky=%0b turns=%0d (t=%0t)",
                             bin_out, step_up, step_down, jump_err, err_sticky, $signed(turns),
                             e.bin, e.up, e.dn, e.jmp, e.sticky, e.turns, $time);
            end
        end else begin
            chk("flags_idle", int'({step_up, step_down, jump_err}), 0);
        end
    end

    initial begin
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_bin_out", int'(bin_out), 0);
        chk("rst_flags", int'({step_up, step_down, jump_err}), 0);
        chk("rst_sticky", int'(err_sticky), 0);
        chk("rst_turns", int'(turns), 0);

        // first sample unprimed, then a short up-count
        cyc(0, 0, 0, 0);
        put_bin(0); idle(3);
        put_bin(0); put_bin(1); put_bin(2); put_bin(3); idle(3);

        // wrap up then back down
        put_bin(15); put_bin(0); put_bin(15); idle(3);

        // jump, clear alone, clear coincident with a new jump
        put_bin(0); put_bin(4); idle(3);
        cyc(0, 0, 1, 0); idle(2);
        @(negedge clk);
        chk("sticky_after_clr", int'(err_sticky), int'(m_sticky));
        put_bin(10); cyc(0, 0, 1, 0); idle(3);
        @(negedge clk);
        chk("sticky_set_wins", int'(err_sticky), 1);

        // reset one cycle after a sample; next sample unprimed
        put_bin(5); cyc(0, 0, 0, 1); idle(3);
        put_bin(1); idle(3);

        // down-wraps to negative saturation, then up-wraps to positive saturation
        put_bin(0);
        for (int r = 0; r < 3; r++)
            for (int b = N - 1; b >= 0; b--) put_bin(b);
        idle(3);
        @(negedge clk);
        chk("turns_sat_min", int'($signed(turns)), TMIN);
        for (int r = 0; r < 4; r++)
            for (int b = 1; b <= N; b++) put_bin(b % N);
        idle(3);
        @(negedge clk);
        chk("turns_sat_max", int'($signed(turns)), TMAX);

`ifdef GRAY_FILTER_EN
        cyc(0, 0, 0, 1); idle(1);
        put_bin(1); put_bin(2); put_bin(1); put_bin(1); put_bin(1); idle(4);
`endif

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            int sel, nb;
            bit v, clr, r;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3: nb = (last_bin + 1) % N;
                4, 5, 6:    nb = (last_bin + N - 1) % N;
                7:          nb = last_bin;
                default:    nb = int'($urandom_range(0, N - 1));
            endcase
            v   = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 9) == 0);
            r   = ($urandom_range(0, 99) < 2);
            cyc(v, b2g(nb), clr, r);
        end
        idle(6);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
